// File: rtl/umem_arb.sv
// Byte-addressed RAM window shared by a CPU load/store port and an AXI-side word port.
// Optional build macro UMEM_MISALIGN_ERR_EN turns misaligned accesses into errors/dropped ops.
module umem_arb #(
  parameter logic [31:0] BASE_ADDR    = 32'hA000_0000,
  parameter int unsigned DEPTH_BYTES  = 512,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [2:0]  cpu_funct3,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  input  logic        axi_req,
  output logic        axi_ready,
  input  logic        axi_we,
  input  logic [31:0] axi_addr,
  input  logic [31:0] axi_wdata,
  output logic        axi_rvalid,
  output logic [31:0] axi_rdata
);

  localparam int unsigned AW        = $clog2(DEPTH_BYTES);
  localparam logic [3:0]  StarveMax = 4'(STARVE_LIMIT);

  if (DEPTH_BYTES < 8 || (DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0) begin : g_bad_depth
    $error("umem_arb: DEPTH_BYTES must be a power of two >= 8");
  end
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("umem_arb: STARVE_LIMIT must be in 1..15");
  end

  logic [7:0] mem [DEPTH_BYTES];

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       axi_grant, cpu_grant;

  assign axi_grant = axi_req & (~cpu_req | (starve_cnt_q == StarveMax));
  assign cpu_grant = cpu_req & ~axi_grant;
  assign axi_ready = axi_grant;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!axi_req || axi_grant) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q != StarveMax) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // CPU request decode
  // ---------------------------------------------------------------------------
  logic [31:0] cpu_off;
  logic        cpu_in_win;
  logic [3:0]  cpu_lanes;
  logic        cpu_f3_ok;
  logic        cpu_misalign;
  logic        cpu_ok;

  assign cpu_off    = cpu_addr - BASE_ADDR;
  assign cpu_in_win = (cpu_addr >= BASE_ADDR) && (cpu_off < 32'(DEPTH_BYTES));

  always_comb begin
    cpu_lanes = 4'b0000;
    cpu_f3_ok = 1'b0;
    case (cpu_funct3)
      3'b000: begin cpu_lanes = 4'b0001; cpu_f3_ok = 1'b1;    end
      3'b001: begin cpu_lanes = 4'b0011; cpu_f3_ok = 1'b1;    end
      3'b010: begin cpu_lanes = 4'b1111; cpu_f3_ok = 1'b1;    end
      // Unsigned variants exist only for loads.
      3'b100: begin cpu_lanes = 4'b0001; cpu_f3_ok = ~cpu_we; end
      3'b101: begin cpu_lanes = 4'b0011; cpu_f3_ok = ~cpu_we; end
      default: begin cpu_lanes = 4'b0000; cpu_f3_ok = 1'b0;    end
    endcase
  end

`ifdef UMEM_MISALIGN_ERR_EN
  assign cpu_misalign = ((cpu_funct3[1:0] == 2'b01) && cpu_off[0]) ||
                        ((cpu_funct3[1:0] == 2'b10) && (cpu_off[1:0] != 2'b00));
`else
  assign cpu_misalign = 1'b0;
`endif

  assign cpu_ok = cpu_in_win & cpu_f3_ok & ~cpu_misalign;

  // ---------------------------------------------------------------------------
  // AXI request decode
  // ---------------------------------------------------------------------------
  logic [31:0] axi_off;
  logic        axi_in_win;
  logic        axi_misalign;
  logic        axi_ok;

  assign axi_off    = axi_addr - BASE_ADDR;
  assign axi_in_win = (axi_addr >= BASE_ADDR) && (axi_off < 32'(DEPTH_BYTES));

`ifdef UMEM_MISALIGN_ERR_EN
  assign axi_misalign = (axi_addr[1:0] != 2'b00);
`else
  assign axi_misalign = 1'b0;
`endif

  assign axi_ok = axi_in_win & ~axi_misalign;

  // ---------------------------------------------------------------------------
  // Shared RAM access path (at most one port granted per cycle)
  // ---------------------------------------------------------------------------
  logic [AW-1:0] acc_off;
  logic [3:0]    acc_lanes;
  logic [31:0]   acc_wdata;
  logic          mem_we;
  logic [AW-1:0] lane_idx [4];
  logic [31:0]   rd_word;

  assign acc_off   = axi_grant ? axi_off[AW-1:0] : cpu_off[AW-1:0];
  assign acc_lanes = axi_grant ? 4'b1111 : cpu_lanes;
  assign acc_wdata = axi_grant ? axi_wdata : cpu_wdata;
  // An access presented together with rst is treated as never accepted.
  assign mem_we    = ~rst & (axi_grant ? (axi_ok & axi_we) : (cpu_grant & cpu_ok & cpu_we));

  // Each lane wraps independently inside the window.
  always_comb begin
    rd_word = 32'd0;
    for (int i = 0; i < 4; i++) begin
      lane_idx[i]        = acc_off + AW'(i);
      rd_word[8*i +: 8]  = mem[lane_idx[i]];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && acc_lanes[i]) begin
        mem[lane_idx[i]] <= acc_wdata[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load formatting and registered responses
  // ---------------------------------------------------------------------------
  logic [31:0] load_fmt;
  logic [31:0] cpu_rdata_d, axi_rdata_d;

  always_comb begin
    case (cpu_funct3)
      3'b000:  load_fmt = {{24{rd_word[7]}}, rd_word[7:0]};
      3'b100:  load_fmt = {24'd0, rd_word[7:0]};
      3'b001:  load_fmt = {{16{rd_word[15]}}, rd_word[15:0]};
      3'b101:  load_fmt = {16'd0, rd_word[15:0]};
      default: load_fmt = rd_word;
    endcase
  end

  assign cpu_rdata_d = (cpu_ok && !cpu_we) ? load_fmt : 32'd0;
  assign axi_rdata_d = (axi_ok && !axi_we) ? rd_word : 32'd0;

  logic        cpu_ack_q, cpu_err_q, axi_rvalid_q;
  logic [31:0] cpu_rdata_q, axi_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= 4'd0;
      cpu_ack_q    <= 1'b0;
      cpu_err_q    <= 1'b0;
      cpu_rdata_q  <= 32'd0;
      axi_rvalid_q <= 1'b0;
      axi_rdata_q  <= 32'd0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      cpu_ack_q    <= cpu_grant;
      cpu_err_q    <= cpu_grant & ~cpu_ok;
      axi_rvalid_q <= axi_grant;
      if (cpu_grant) begin
        cpu_rdata_q <= cpu_rdata_d;
      end
      if (axi_grant) begin
        axi_rdata_q <= axi_rdata_d;
      end
    end
  end

  assign cpu_ack    = cpu_ack_q;
  assign cpu_err    = cpu_err_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign axi_rvalid = axi_rvalid_q;
  assign axi_rdata  = axi_rdata_q;

endmodule
